// File: rtl/sram_sprite_writer.sv
// Sprite SRAM write engine: streams one sprite region of 16-bit words into the async SRAM.
// Optional readback check of every word is enabled with `define SRAM_WRITE_VERIFY_EN.
module sram_sprite_writer #(
    parameter int unsigned WORDS_PER_SPRITE = 282,
    parameter int unsigned SPRITE_STRIDE    = 512,
    parameter logic [19:0] BASE_ADDR        = 20'h00000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [3:0]  spriteNum,
    input  logic        bus_grant,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [19:0] ADDR,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [15:0] Data_to_SRAM,
    output logic        data_drive,
    input  logic [15:0] Data_from_SRAM,
    output logic        busy,
    output logic        writeDone,
    output logic        verify_error
);

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = (WORDS_PER_SPRITE > 1) ? $clog2(WORDS_PER_SPRITE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS_PER_SPRITE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_VSETUP,
        ST_VSAMPLE,
        ST_DONE
    } state_t;

    state_t        state_q;
    logic [AW-1:0] base_q;
    logic [IW-1:0] idx_q;
    logic [DW-1:0] data_q;
    logic [AW-1:0] addr_q;
    logic          ce_q;
    logic          ub_q;
    logic          lb_q;
    logic          oe_q;
    logic          we_q;
    logic          drive_q;
    logic          busy_q;
    logic          done_q;
    logic          verr_q;

    logic [AW-1:0] base_d;
    logic [AW-1:0] addr_d;
    logic          word_end_c;

    // Region origin and word address, both wrapping modulo 2^20
    assign base_d = BASE_ADDR + (AW'(spriteNum) * AW'(SPRITE_STRIDE));
    assign addr_d = base_q + AW'(idx_q);

`ifdef SRAM_WRITE_VERIFY_EN
    assign word_end_c = (state_q == ST_VSAMPLE);
`else
    logic unused_rd_c;
    assign unused_rd_c = ^Data_from_SRAM;
    assign word_end_c  = (state_q == ST_HOLD);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            ce_q    <= 1'b1;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            drive_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            verr_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q  <= base_d;
                        idx_q   <= '0;
                        verr_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (wr_valid && bus_grant) begin
                        data_q  <= wr_data;
                        addr_q  <= addr_d;
                        ce_q    <= 1'b0;
                        ub_q    <= 1'b0;
                        lb_q    <= 1'b0;
                        drive_q <= 1'b1;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    we_q    <= 1'b0;
                    state_q <= ST_PULSE;
                end
                ST_PULSE: begin
                    we_q    <= 1'b1;
                    state_q <= ST_HOLD;
                end
`ifdef SRAM_WRITE_VERIFY_EN
                // Release the pad before opening the SRAM output drivers
                ST_HOLD: begin
                    drive_q <= 1'b0;
                    oe_q    <= 1'b0;
                    state_q <= ST_VSETUP;
                end
                ST_VSETUP: begin
                    state_q <= ST_VSAMPLE;
                end
                ST_VSAMPLE: begin
                    if (Data_from_SRAM != data_q) begin
                        verr_q <= 1'b1;
                    end
                end
`else
                ST_HOLD: begin
                end
`endif
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Last cycle of a word: release the bus and pick the next word or finish
            if (word_end_c) begin
                ce_q    <= 1'b1;
                ub_q    <= 1'b1;
                lb_q    <= 1'b1;
                oe_q    <= 1'b1;
                drive_q <= 1'b0;
                if (idx_q == LAST_IDX) begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_DONE;
                end else begin
                    idx_q   <= idx_q + IW'(1);
                    state_q <= ST_LOAD;
                end
            end
        end
    end

    // Combinational so acceptance follows bus_grant within the same cycle
    assign wr_ready     = (state_q == ST_LOAD) && bus_grant;
    assign ADDR         = addr_q;
    assign CE           = ce_q;
    assign UB           = ub_q;
    assign LB           = lb_q;
    assign OE           = oe_q;
    assign WE           = we_q;
    assign Data_to_SRAM = data_q;
    assign data_drive   = drive_q;
    assign busy         = busy_q;
    assign writeDone    = done_q;
    assign verify_error = verr_q;

endmodule

// File: tb/tb_sram_sprite_writer.sv
// Scoreboard bench for sram_sprite_writer: reference address/data model, SRAM model, bus and reset events.
module tb_sram_sprite_writer;

    localparam int unsigned WORDS  = 282;
    localparam int unsigned STRIDE = 512;
    localparam logic [19:0] BASE   = 20'h00000;
`ifdef SRAM_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int unsigned CYC_PER_WORD = VERIFY ? 6 : 4;

    typedef struct {
        logic [19:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [3:0]  spriteNum;
    logic        bus_grant;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [19:0] ADDR;
    logic        CE, UB, LB, OE, WE;
    logic [15:0] Data_to_SRAM;
    logic        data_drive;
    logic [15:0] Data_from_SRAM;
    logic        busy;
    logic        writeDone;
    logic        verify_error;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          job_pops = 0;
    bit          job_corrupt = 1'b0;
    logic [19:0] corrupt_addr = '0;
    wr_t         exp_q[$];
    int          done_q[$];
    logic [15:0] mem [0:8191];

    sram_sprite_writer #(
        .WORDS_PER_SPRITE(WORDS),
        .SPRITE_STRIDE(STRIDE),
        .BASE_ADDR(BASE)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .start(start),
        .spriteNum(spriteNum),
        .bus_grant(bus_grant),
        .wr_data(wr_data),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .ADDR(ADDR),
        .CE(CE),
        .UB(UB),
        .LB(LB),
        .OE(OE),
        .WE(WE),
        .Data_to_SRAM(Data_to_SRAM),
        .data_drive(data_drive),
        .Data_from_SRAM(Data_from_SRAM),
        .busy(busy),
        .writeDone(writeDone),
        .verify_error(verify_error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // SRAM read model; one chosen address reads back inverted
    assign Data_from_SRAM = (!OE && !data_drive)
        ? ((job_corrupt && ADDR == corrupt_addr) ? ~mem[ADDR[12:0]] : mem[ADDR[12:0]])
        : 16'h0000;

    function automatic logic [19:0] word_addr(input logic [3:0] s, input int k);
        return 20'(32'(BASE) + 32'(s) * STRIDE + 32'(k));
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp_v, cyc);
        end
    endtask

    task automatic fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    // Monitor: pops the scoreboard on each WE falling edge and checks word timing
    initial begin : monitor
        bit          prev_we;
        int          ph;
        logic [19:0] a0;
        logic [15:0] d0;
        wr_t         e;
        bit          hs;
        prev_we = 1'b1;
        ph = 0;
        a0 = '0;
        d0 = '0;
        forever begin
            @(negedge Clk);
            #2;
            if (Reset) begin
                prev_we = 1'b1;
                ph = 0;
                continue;
            end
            hs = wr_valid && wr_ready;
            if (ph == 1) begin
                a0 = ADDR;
                d0 = Data_to_SRAM;
            end
            if (ph != 0) begin
                check("word_phase", 32'({WE, OE, data_drive, ADDR == a0, Data_to_SRAM == d0, CE}),
                      32'({ph != 2, 5'b11110}));
                ph = (ph == 3) ? 0 : ph + 1;
            end
            if (prev_we && !WE) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(ADDR), 32'(e.addr));
                    check("wr_data", 32'(Data_to_SRAM), 32'(e.data));
                    mem[ADDR[12:0]] = Data_to_SRAM;
                    job_pops++;
                end
            end
            prev_we = WE;
            if (!OE && data_drive) fail("oe_low_while_driving");
            if (hs) begin
                check("verify_flag", 32'(verify_error), 32'(VERIFY && job_corrupt && job_pops > 10));
                ph = 1;
            end
            if (writeDone) begin
                check("done_busy", 32'(busy), 32'd0);
                check("done_all_words", 32'(exp_q.size()), 32'd0);
                check("done_verify", 32'(verify_error), 32'(VERIFY && job_corrupt && job_pops > 10));
                if (done_q.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    int t;
                    t = done_q.pop_front();
                    if (t >= 0) check("done_latency", 32'(cyc), 32'(t));
                end
            end
        end
    end

    // mode: 0 = job will be aborted, 1 = completion expected, 2 = completion at exact latency
    task automatic start_job(input logic [3:0] s, input bit corrupt, input int mode);
        @(negedge Clk);
        start = 1'b1;
        spriteNum = s;
        job_pops = 0;
        job_corrupt = corrupt;
        corrupt_addr = word_addr(s, 10);
        @(negedge Clk);
        start = 1'b0;
        if (mode == 2) done_q.push_back(cyc + int'(WORDS * CYC_PER_WORD));
        else if (mode == 1) done_q.push_back(-1);
    endtask

    task automatic send_job(input logic [3:0] s, input bit incr, input bit toggle, input int abort_at);
        wr_t e;
        int  guard;
        for (int k = 0; k < int'(WORDS); k++) begin
            e.addr = word_addr(s, k);
            e.data = incr ? 16'(k) : 16'($urandom);
            exp_q.push_back(e);
            wr_data = e.data;
            guard = 0;
            forever begin
                wr_valid = toggle ? ~wr_valid : 1'b1;
                #1;
                if (wr_valid && wr_ready) break;
                guard++;
                if (guard > 50) begin
                    fail("handshake_timeout");
                    wr_valid = 1'b0;
                    return;
                end
                @(negedge Clk);
            end
            @(negedge Clk);
            if (k == abort_at) begin
                @(negedge Clk);
                check("abort_in_pulse", 32'(WE), 32'd0);
                Reset = 1'b1;
                wr_valid = 1'b0;
                exp_q.delete();
                @(negedge Clk);
                #3;
                check("abort_outputs", 32'({WE, CE, data_drive, busy, writeDone}), 32'(5'b11000));
                @(negedge Clk);
                #3;
                check("abort_no_done", 32'({busy, writeDone}), 32'd0);
                Reset = 1'b0;
                return;
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge Clk);
            #3;
            if (writeDone) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            fail("done_timeout");
            return;
        end
        start = 1'b1;
        spriteNum = 4'hA;
        @(negedge Clk);
        start = 1'b0;
        #3;
        check("start_in_done_ignored", 32'({busy, writeDone}), 32'd0);
        @(negedge Clk);
        #3;
        check("idle_after_done", 32'({busy, wr_ready, CE, WE}), 32'(4'b0011));
    endtask

    task automatic grant_drop();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge Clk);
            if (!WE && job_pops == 5) got = 1'b1;
        end
        if (!got) begin
            fail("grant_drop_not_reached");
            return;
        end
        bus_grant = 1'b0;
        repeat (8) begin
            @(negedge Clk);
            #3;
            check("ready_without_grant", 32'(wr_ready), 32'd0);
        end
        check("words_held_without_grant", 32'(job_pops), 32'd6);
        @(negedge Clk);
        bus_grant = 1'b1;
    endtask

    task automatic extra_start(input logic [3:0] s);
        repeat (40) @(negedge Clk);
        start = 1'b1;
        spriteNum = ~s;
        @(negedge Clk);
        start = 1'b0;
        #3;
        check("busy_after_extra_start", 32'(busy), 32'd1);
    endtask

    initial begin : main
        logic [3:0] s;
        Reset = 1'b1;
        start = 1'b0;
        spriteNum = '0;
        bus_grant = 1'b1;
        wr_data = '0;
        wr_valid = 1'b0;
        repeat (3) @(negedge Clk);
        #3;
        check("reset_state",
              32'({ADDR, CE, UB, LB, OE, WE, data_drive, wr_ready, busy, writeDone, verify_error}),
              32'({20'h00000, 5'b11111, 5'b00000}));
        @(negedge Clk);
        Reset = 1'b0;

        start_job(4'd3, 1'b0, 2);
        send_job(4'd3, 1'b1, 1'b0, -1);
        wait_done();

        start_job(4'd2, 1'b0, 0);
        send_job(4'd2, 1'b0, 1'b0, 3);

        start_job(4'd0, 1'b0, 2);
        send_job(4'd0, 1'b0, 1'b0, -1);
        wait_done();

        start_job(4'd7, 1'b0, 1);
        fork
            send_job(4'd7, 1'b0, 1'b0, -1);
            grant_drop();
        join
        wait_done();

        start_job(4'd5, 1'b1, 2);
        send_job(4'd5, 1'b0, 1'b0, -1);
        wait_done();

        s = 4'($urandom_range(0, 15));
        start_job(s, 1'b0, 1);
        fork
            send_job(s, 1'b0, 1'b1, -1);
            extra_start(s);
        join
        wait_done();

        check("end_writes_pending", 32'(exp_q.size()), 32'd0);
        check("end_done_pending", 32'(done_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_sprite_writer.md
Name: sram_sprite_writer

Overview:
- Loads sprite pixel words into the off-chip 16-bit SRAM, one sprite region per job; this is the write side of the sprite SRAM path, the counterpart of the sprite reader.
- Takes a stream of 16-bit words over a valid/ready handshake and generates the active-low SRAM control and write strobes.
- Places each word at BASE_ADDR + spriteNum*SPRITE_STRIDE + index.
- Shares the SRAM bus with the reader through an external bus_grant; the top level owns the tristate data pad.

Parameters:
- WORDS_PER_SPRITE, 282: words written per job (4500 bits rounded up to 16-bit words).
- SPRITE_STRIDE, 512: address spacing between sprite regions.
- BASE_ADDR, 20'h00000: address of sprite 0, word 0.

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- start  in  1  one-cycle job request; ignored while busy
- spriteNum  in  4  sprite region select, latched on an accepted start
- bus_grant  in  1  SRAM bus owned by writer when high
- wr_data  in  16  word to store
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  writer accepts wr_data this cycle
- ADDR  out  20  SRAM address
- CE, UB, LB, OE, WE  out  1 each  SRAM controls, active-low
- Data_to_SRAM  out  16  write data to the pad
- data_drive  out  1  pad output enable, high = drive Data_to_SRAM
- Data_from_SRAM  in  16  pad read data (used only with the optional feature)
- busy  out  1  job in progress
- writeDone  out  1  one-cycle pulse when a job completes
- verify_error  out  1  sticky readback mismatch flag

Behaviour:
- Reset values: state IDLE; CE, UB, LB, OE, WE = 1; data_drive = 0; wr_ready = 0; busy = 0; writeDone = 0; verify_error = 0; ADDR = 0; word index = 0.
- Reset mid-operation: all of the above take effect on the same edge, including deassertion of WE; the partial job is abandoned and no writeDone is pulsed.
- IDLE: start=1 latches spriteNum, clears the index and verify_error, then goes to LOAD with busy=1.
- LOAD:
  - wr_ready = bus_grant.
  - On wr_valid && wr_ready: latch wr_data into the data register, then go to SETUP.
  - Otherwise stay in LOAD. CE=1, data_drive=0 while waiting.
- SETUP: ADDR = base + index; Data_to_SRAM = latched word; data_drive=1; CE=UB=LB=0; OE=1; WE=1.
- PULSE: as SETUP but WE=0.
- HOLD:
  - WE=1; ADDR and data held; data_drive=1.
  - If index == WORDS_PER_SPRITE-1, go to DONE; otherwise increment the index and go to LOAD.
- DONE: writeDone=1 for exactly one cycle, busy=0; next state IDLE.
- Throughput and latency: minimum 4 cycles per word. A word accepted at edge N has WE low during cycle N+2.
- bus_grant dropping during SETUP, PULSE or HOLD does not abort the word; the current word completes and the writer then waits in LOAD.
- ADDR arithmetic is done in 20 bits, wrapping modulo 2^20: BASE_ADDR + spriteNum*SPRITE_STRIDE + index. The index counter is $clog2(WORDS_PER_SPRITE) bits wide.
- OE is never 0 while data_drive=1.
- Address and data change only while WE=1.
- start asserted in DONE is ignored; it is accepted only in IDLE.

Optional Feature:
- Macro: SRAM_WRITE_VERIFY_EN.
- With the macro defined:
  - HOLD goes to VSETUP instead of LOAD/DONE.
  - VSETUP: data_drive=0, CE=OE=UB=LB=0, WE=1, same ADDR.
  - VSAMPLE: same controls. Data_from_SRAM is compared to the latched word; a mismatch sets verify_error, which stays set until the next accepted start.
  - VSAMPLE then takes the index/DONE decision.
  - Minimum 6 cycles per word.
- Without the macro: no verify states; Data_from_SRAM is unused; verify_error is tied to 0.

Test Plan:
- Reset, then start with spriteNum=3 and wr_valid held high with words 16'h0000 upward -> 282 WE low pulses. First ADDR = 20'h00600, last = 20'h00719. writeDone pulses once, 1128 cycles after start (no verify).
- One word accepted -> in the following cycles WE is 1,0,1. ADDR and Data_to_SRAM are stable across all three cycles. OE=1 and data_drive=1 throughout.
- bus_grant dropped during PULSE of word 5 -> word 5 completes. wr_ready stays 0 until bus_grant returns, then word 6 continues at offset 6.
- Reset asserted during PULSE -> WE=1, CE=1 and data_drive=0 on the next edge. busy=0, no writeDone. A new start with spriteNum=0 writes beginning at 20'h00000.
- start pulsed while busy, and wr_valid toggling every other cycle -> the extra start is ignored; exactly 282 words are written, in order.
- With SRAM_WRITE_VERIFY_EN, the SRAM model corrupts word 10 -> verify_error=1 after that word's VSAMPLE. It stays 1 through writeDone and clears on the next start.
